// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder: reuses one 4-bit ripple-carry adder over NIBBLES slices, LSB nibble first.
// Optional signed-overflow output is enabled by defining WAS_OVF_EN.

module ripple_carry (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;

   assign c[0] = ci;

   for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
   end

   assign co = c[4];
endmodule

module wide_add_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   cin,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout
`ifdef WAS_OVF_EN
   ,
   output logic                   ovf
`endif
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_reg;
   state_t          state_next;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic            carry_reg;
   logic [IW-1:0]   idx_reg;
   logic [3:0]      sum_nib_reg [NIBBLES];
   logic            cout_reg;
   logic            busy_reg;
   logic            done_reg;

   logic            accept;
   logic            run;
   logic            last;
   logic [3:0]      a_nib [NIBBLES];
   logic [3:0]      b_nib [NIBBLES];
   logic [3:0]      add_a;
   logic [3:0]      add_b;
   logic [3:0]      add_s;
   logic            add_co;

   // The single shared slice adder; operands are muxed by the nibble index.
   assign add_a = a_nib[idx_reg];
   assign add_b = b_nib[idx_reg];

   ripple_carry u_adder (
      .a  (add_a),
      .b  (add_b),
      .ci (carry_reg),
      .s  (add_s),
      .co (add_co)
   );

   assign run    = (state_reg == RUN);
   assign last   = (idx_reg == IW'(NIBBLES - 1));
   assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    state_next = accept ? RUN : IDLE;
         RUN:     state_next = last ? DONE : RUN;
         DONE:    state_next = accept ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         idx_reg   <= '0;
         cout_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         busy_reg  <= (state_next == RUN);
         done_reg  <= (state_next == DONE);
         if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
         end else if (run) begin
            carry_reg <= add_co;
            idx_reg   <= last ? '0 : idx_reg + IW'(1);
            if (last) begin
               cout_reg <= add_co;
            end
         end
      end
   end

   // Each result nibble has its own register so only the active slice is written.
   for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
      assign sum[4*gi +: 4] = sum_nib_reg[gi];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sum_nib_reg[gi] <= 4'h0;
         end else if (run && (idx_reg == IW'(gi))) begin
            sum_nib_reg[gi] <= add_s;
         end
      end
   end

`ifdef WAS_OVF_EN
   logic ovf_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_reg <= 1'b0;
      end else if (run && last) begin
         ovf_reg <= (a_reg[W-1] == b_reg[W-1]) && (add_s[3] != a_reg[W-1]);
      end
   end

   assign ovf = ovf_reg;
`endif

   assign busy = busy_reg;
   assign done = done_reg;
   assign cout = cout_reg;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed and randomized checks of wide_add_sequencer at NIBBLES=4 and NIBBLES=2.

module tb_wide_add_sequencer;
   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        cout;

   logic        start2;
   logic [7:0]  a2;
   logic [7:0]  b2;
   logic        cin2;
   logic        busy2;
   logic        done2;
   logic [7:0]  sum2;
   logic        cout2;
`ifdef WAS_OVF_EN
   logic        ovf;
   logic        ovf2;
`endif

   int total;
   int bad;
   int n;

   wide_add_sequencer #(.NIBBLES(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef WAS_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   wide_add_sequencer #(.NIBBLES(2)) dut2 (
      .clk   (clk),
      .rst   (rst),
      .start (start2),
      .a     (a2),
      .b     (b2),
      .cin   (cin2),
      .busy  (busy2),
      .done  (done2),
      .sum   (sum2),
      .cout  (cout2)
`ifdef WAS_OVF_EN
      ,
      .ovf   (ovf2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns just after the start edge E0.
   task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic cv);
      @(negedge clk);
      a = av;
      b = bv;
      cin = cv;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(output int cnt);
      cnt = 0;
      while (!done && cnt < 20) begin
         @(posedge clk);
         #1 cnt++;
      end
   endtask

   task automatic start_op2(input logic [7:0] av, input logic [7:0] bv, input logic cv);
      @(negedge clk);
      a2 = av;
      b2 = bv;
      cin2 = cv;
      start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
   endtask

   task automatic wait_done2(output int cnt);
      cnt = 0;
      while (!done2 && cnt < 20) begin
         @(posedge clk);
         #1 cnt++;
      end
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      logic [16:0] exp17;
      logic [7:0]  ra2;
      logic [7:0]  rb2;
      logic [8:0]  exp9;

      total = 0;
      bad = 0;
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      start2 = 1'b0;
      a2 = '0;
      b2 = '0;
      cin2 = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_sum", sum, 0);
      check("reset_cout", cout, 0);
`ifdef WAS_OVF_EN
      check("reset_ovf", ovf, 0);
`endif
      @(negedge clk) rst = 1'b0;

      // Reset during the 2nd RUN cycle clears outputs without a clock edge.
      start_op(16'hABCD, 16'h1111, 1'b0);
      @(posedge clk);
      #1 check("midrun_busy_before", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("midrun_sum", sum, 0);
      check("midrun_busy", busy, 0);
      check("midrun_done", done, 0);
      check("midrun_cout", cout, 0);
      @(negedge clk) rst = 1'b0;

      start_op(16'h0001, 16'h0001, 1'b0);
      wait_done(n);
      check("after_reset_latency", n, 4);
      check("after_reset_sum", sum, 16'h0002);

      // Full carry ripple through every nibble.
      start_op(16'hFFFF, 16'h0001, 1'b0);
      wait_done(n);
      check("ripple_latency", n, 4);
      check("ripple_sum", sum, 16'h0000);
      check("ripple_cout", cout, 1);
      check("ripple_busy_in_done", busy, 0);
      @(posedge clk);
      #1;
      check("ripple_done_one_cycle", done, 0);
      check("ripple_idle_busy", busy, 0);

      // Carry-in, with a start pulse during RUN that must be ignored.
      start_op(16'h1234, 16'h4321, 1'b1);
      @(negedge clk);
      start = 1'b1;
      a = 16'hFFFF;
      b = 16'hFFFF;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(n);
      check("cin_latency", n, 3);
      check("cin_sum", sum, 16'h5556);
      check("cin_cout", cout, 0);

      // Back-to-back starts issued in the DONE cycle.
      start_op(16'h8000, 16'h8000, 1'b0);
      wait_done(n);
      check("b2b1_latency", n, 4);
      check("b2b1_sum", sum, 16'h0000);
      check("b2b1_cout", cout, 1);
`ifdef WAS_OVF_EN
      check("b2b1_ovf", ovf, 1);
`endif
      start_op(16'h7FFF, 16'h0001, 1'b0);
      wait_done(n);
      check("b2b2_latency", n, 4);
      check("b2b2_sum", sum, 16'h8000);
      check("b2b2_cout", cout, 0);
`ifdef WAS_OVF_EN
      check("b2b2_ovf", ovf, 1);
`endif

      // Result holds while idle.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("hold_sum", sum, 16'h8000);
         check("hold_done", done, 0);
      end
      check("hold_cout", cout, 0);

      // Random sweep, NIBBLES=4, back-to-back.
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         exp17 = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
         start_op(ra, rb, rc);
         wait_done(n);
         check("rand4_spacing", n, 4);
         check("rand4_result", {cout, sum}, exp17);
      end

      // Random sweep, NIBBLES=2, back-to-back.
      for (int i = 0; i < 1000; i++) begin
         ra2 = 8'($urandom);
         rb2 = 8'($urandom);
         rc = 1'($urandom);
         exp9 = {1'b0, ra2} + {1'b0, rb2} + {8'h0, rc};
         start_op2(ra2, rb2, rc);
         wait_done2(n);
         check("rand2_spacing", n, 2);
         check("rand2_result", {cout2, sum2}, exp9);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
